// File: rtl/game_score_counter_pkg.sv
// Shared definitions for the dino game score path: run-state encoding,
// score width, default saturation value and BCD digit geometry.
package game_score_counter_pkg;
  localparam int SCORE_W       = 14;
  localparam int MAX_SCORE_DEF = 9999;
  localparam int DIGIT_W       = 4;
  localparam int NUM_DIGITS    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;
endpackage

// File: rtl/game_score_counter_bcd_digit.sv
// bcd_digit_counter: one decimal decade of the HUD score copy.
// Ports:
//   clk, rst   - clock, async active-high reset
//   clr        - synchronous clear to 0 (wins over inc)
//   inc        - advance this digit by one
//   digit      - registered BCD digit 0..9
//   carry      - combinational: digit is 9 and inc is high (rolls next decade)
module bcd_digit_counter
  import game_score_counter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);
  logic [DIGIT_W-1:0] r_digit;
  logic               w_at9;

  assign w_at9 = (r_digit == DIGIT_W'(9));
  assign carry = inc && w_at9;
  assign digit = r_digit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_digit <= '0;
    else if (clr)  r_digit <= '0;
    else if (inc)  r_digit <= w_at9 ? '0 : r_digit + DIGIT_W'(1);
  end
endmodule

// File: rtl/game_score_counter.sv
// game_score_counter: run-state FSM, tick prescaler, saturating binary score,
// session high score, milestone pulse and a 4-digit BCD copy of the score.
// Ports:
//   clk, rst    - clock, async active-high reset
//   start       - begin/restart a run (ignored while running)
//   crash       - end the current run (ignored unless running)
//   game_score  - current score, binary
//   high_score  - best final score since reset
//   score_bcd   - game_score as BCD, [15:12] = thousands
//   running     - high in RUN
//   game_over   - high in OVER
//   milestone   - one-cycle pulse when score reaches a nonzero multiple of MILESTONE
module game_score_counter
  import game_score_counter_pkg::*;
#(
  parameter int TICK_DIV  = 10_000_000,
  parameter int MAX_SCORE = MAX_SCORE_DEF,
  parameter int MILESTONE = 100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          crash,
  output logic [SCORE_W-1:0]            game_score,
  output logic [SCORE_W-1:0]            high_score,
  output logic [NUM_DIGITS*DIGIT_W-1:0] score_bcd,
  output logic                          running,
  output logic                          game_over,
  output logic                          milestone
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int MW = $clog2(MILESTONE + 1);

  state_t                             r_state;
  logic [PW-1:0]                      r_pre;
  logic [MW-1:0]                      r_ms_cnt;
  logic [SCORE_W-1:0]                 r_score, r_high;
  logic                               r_running, r_over, r_milestone;

  logic                               w_wrap, w_inc, w_clr;
  logic [NUM_DIGITS-1:0]              w_dinc, w_carry;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_digit;
  logic                               w_unused;

  assign w_wrap = (r_pre == PW'(TICK_DIV - 1));
  // Crash on a wrap edge drops the tick; saturation gates the whole chain.
  assign w_inc  = (r_state == ST_RUN) && !crash && w_wrap &&
                  (r_score < SCORE_W'(MAX_SCORE));
  assign w_clr  = start && (r_state != ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pre       <= '0;
      r_score     <= '0;
      r_high      <= '0;
      r_ms_cnt    <= MW'(MILESTONE - 1);
      r_running   <= 1'b0;
      r_over      <= 1'b0;
      r_milestone <= 1'b0;
    end else begin
      r_milestone <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_pre     <= '0;
            r_score   <= '0;
            r_ms_cnt  <= MW'(MILESTONE - 1);
            r_running <= 1'b1;
            r_over    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (crash) begin
            r_state   <= ST_OVER;
            r_running <= 1'b0;
            r_over    <= 1'b1;
            if (r_score > r_high) r_high <= r_score;
          end else begin
            r_pre <= w_wrap ? '0 : r_pre + PW'(1);
            if (w_inc) begin
              r_score <= r_score + SCORE_W'(1);
              // Down-counter hits 0 on every MILESTONE-th increment since clear.
              if (r_ms_cnt == '0) begin
                r_milestone <= 1'b1;
                r_ms_cnt    <= MW'(MILESTONE - 1);
              end else begin
                r_ms_cnt <= r_ms_cnt - MW'(1);
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Ripple chain: each decade advances when the one below rolls over.
  assign w_dinc = {w_carry[NUM_DIGITS-2:0], w_inc};
  // Top carry can never fire since the score saturates at or below 9999.
  assign w_unused = w_carry[NUM_DIGITS-1];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit_counter u_dig (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_clr),
      .inc   (w_dinc[g]),
      .digit (w_digit[g]),
      .carry (w_carry[g])
    );
  end

  assign game_score = r_score;
  assign high_score = r_high;
  assign score_bcd  = w_digit;
  assign running    = r_running;
  assign game_over  = r_over;
  assign milestone  = r_milestone;
endmodule

// File: tb/tb_game_score_counter.sv
module tb_game_score_counter;
  logic        clk = 1'b0;
  logic        rst, start, crash, start2, crash2;
  logic [13:0] gs, hs, gs2, hs2;
  logic [15:0] bcd, bcd2;
  logic        run, ovr, ms, run2, ovr2, ms2;
  int          ncmp = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  game_score_counter #(.TICK_DIV(4), .MAX_SCORE(9999), .MILESTONE(10)) u_dut (
    .clk(clk), .rst(rst), .start(start), .crash(crash),
    .game_score(gs), .high_score(hs), .score_bcd(bcd),
    .running(run), .game_over(ovr), .milestone(ms)
  );

  game_score_counter #(.TICK_DIV(2), .MAX_SCORE(9999), .MILESTONE(10)) u_sat (
    .clk(clk), .rst(rst), .start(start2), .crash(crash2),
    .game_score(gs2), .high_score(hs2), .score_bcd(bcd2),
    .running(run2), .game_over(ovr2), .milestone(ms2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  initial begin
    int          pulses, pedge, sp, last, bcd_bad;
    logic [13:0] s_mid;
    pulses = 0; pedge = 0; sp = 0; last = 0; bcd_bad = 0; s_mid = '0;
    rst = 1'b1; start = 1'b0; crash = 1'b0; start2 = 1'b0; crash2 = 1'b0;

    // reset state
    #2;
    chk("rst_score", gs, 0);
    chk("rst_high", hs, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_run", run, 0);
    chk("rst_over", ovr, 0);
    chk("rst_ms", ms, 0);
    @(negedge clk); rst = 1'b0;

    // start and first ticks
    step(1); start = 1'b1; step(1); start = 1'b0;
    chk("start_run", run, 1);
    chk("start_over", ovr, 0);
    chk("start_score", gs, 0);
    step(3); chk("score_e3", gs, 0);
    step(1); chk("score_e4", gs, 1);
    step(4); chk("score_e8", gs, 2);

    // milestone at score 10 (edge 40)
    for (int e = 9; e <= 41; e++) begin
      step(1);
      if (ms) begin pulses++; pedge = e; end
      if (e == 40) chk("ms_bcd10", bcd, 16'h0010);
    end
    chk("ms_count", pulses, 1);
    chk("ms_edge", pedge, 40);
    chk("ms_score", gs, 10);

    // crash at 7, then restart and crash at 3
    rst = 1'b1; step(1); rst = 1'b0;
    step(1); start = 1'b1; step(1); start = 1'b0;
    step(28); chk("pre_crash7", gs, 7);
    crash = 1'b1; step(1); crash = 1'b0;
    chk("crash_over", ovr, 1);
    chk("crash_run", run, 0);
    chk("crash_high7", hs, 7);
    chk("crash_score7", gs, 7);
    step(6); chk("over_hold", gs, 7);
    start = 1'b1; step(1); start = 1'b0;
    chk("restart_score", gs, 0);
    chk("restart_bcd", bcd, 0);
    chk("restart_run", run, 1);
    step(12); chk("pre_crash3", gs, 3);
    crash = 1'b1; step(1); crash = 1'b0;
    chk("crash3_high", hs, 7);
    chk("crash3_score", gs, 3);
    start = 1'b1; step(1); start = 1'b0;
    chk("restart2_score", gs, 0);
    chk("restart2_high", hs, 7);

    // crash on the wrap edge at score 5
    rst = 1'b1; step(1); rst = 1'b0;
    step(1); start = 1'b1; step(1); start = 1'b0;
    step(23); chk("pre_sim5", gs, 5);
    crash = 1'b1; step(1); crash = 1'b0;
    chk("sim_score", gs, 5);
    chk("sim_high", hs, 5);
    chk("sim_bcd", bcd, 16'h0005);
    chk("sim_over", ovr, 1);
    step(4); chk("sim_hold", gs, 5);

    // async reset mid-run at score 6
    start = 1'b1; step(1); start = 1'b0;
    step(24); chk("pre_arst6", gs, 6);
    #2 rst = 1'b1;
    #1;
    chk("arst_score", gs, 0);
    chk("arst_high", hs, 0);
    chk("arst_bcd", bcd, 0);
    chk("arst_run", run, 0);
    chk("arst_over", ovr, 0);
    @(negedge clk); rst = 1'b0; crash = 1'b1;
    step(2); crash = 1'b0;
    chk("idle_crash_run", run, 0);
    chk("idle_crash_over", ovr, 0);
    chk("idle_crash_score", gs, 0);

    // saturation on the TICK_DIV=2 instance
    start2 = 1'b1; step(1); start2 = 1'b0;
    for (int e = 1; e <= 2 * 9999 + 20; e++) begin
      step(1);
      if (ms2) begin sp++; last = int'(gs2); end
      if (bcd2 !== to_bcd(int'(gs2))) bcd_bad++;
      if (e == 2 * 9999) s_mid = gs2;
    end
    chk("sat_reach", s_mid, 9999);
    chk("sat_hold", gs2, 9999);
    chk("sat_bcd", bcd2, 16'h9999);
    chk("sat_ms_count", sp, 999);
    chk("sat_ms_last", last, 9990);
    chk("sat_bcd_track", bcd_bad, 0);
    chk("sat_run", run2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
